motor_pwm_rx: RTL and testbench

//  Receive-side decoder for the servo/motor PWM stream produced by the motor switch block. Samples pwm_in,

---
 rtl/motor_pwm_rx_pkg.sv | 19 +
 rtl/motor_pwm_rx_if.sv | 12 +
 rtl/motor_pwm_tick_gen.sv | 15 +
 rtl/motor_pwm_rx.sv | 82 ++++++++
 tb/tb_motor_pwm_rx.sv | 132 +++++++++++++
 5 files changed

// File: rtl/motor_pwm_rx_pkg.sv
// motor_pwm_rx_pkg: receiver states, nominal SW-code widths (ticks) and the width classifier.
package motor_pwm_rx_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;
  localparam int unsigned W_SW01 = 130;
  localparam int unsigned W_SW00 = 153;
  localparam int unsigned W_SW10 = 170;
  typedef struct packed {
    logic       ok;
    logic [1:0] code;
  } cls_t;
  function automatic logic near(input int unsigned w, input int unsigned nom, input int unsigned tol);
    return (w + tol >= nom) && (w <= nom + tol);
  endfunction
  function automatic cls_t classify(input int unsigned w, input int unsigned tol);
    return near(w, W_SW01, tol) ? cls_t'{1'b1, 2'b01} :
           near(w, W_SW00, tol) ? cls_t'{1'b1, 2'b00} :
           near(w, W_SW10, tol) ? cls_t'{1'b1, 2'b10} : cls_t'{1'b0, 2'b00};
  endfunction
endpackage

// File: rtl/motor_pwm_rx_if.sv
// motor_pwm_rx_if: PWM input and measurement outputs of the receiver.
interface motor_pwm_rx_if #(parameter int CNT_W = 16);
  logic             pwm_in;
  logic [CNT_W-1:0] width_out;
  logic [CNT_W-1:0] period_out;
  logic             meas_valid;
  logic [1:0]       sw_code;
  logic             code_ok;
  logic             signal_lost;
  modport master (output pwm_in, input width_out, period_out, meas_valid, sw_code, code_ok, signal_lost);
  modport slave (input pwm_in, output width_out, period_out, meas_valid, sw_code, code_ok, signal_lost);
endinterface

// File: rtl/motor_pwm_tick_gen.sv
// motor_pwm_tick_gen: prescaler counting 0..DIVISOR-1, one-clk tick at wrap.
module motor_pwm_tick_gen #(
  parameter int DIVISOR = 500
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int PW = $clog2(DIVISOR + 1);
  logic [PW-1:0] cnt;
  assign tick = cnt == PW'(DIVISOR - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/motor_pwm_rx.sv
// motor_pwm_rx: measures PWM high time and period in ticks and decodes the SW code.
// Optional input glitch filter enabled by defining MOTOR_PWM_RX_GLITCH_EN.
module motor_pwm_rx
  import motor_pwm_rx_pkg::*;
#(
  parameter int DIVISOR = 500,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4000,
  parameter int TOL     = 5
`ifdef MOTOR_PWM_RX_GLITCH_EN
  , parameter int GLITCH_LEN = 4
`endif
) (
  input logic clk,
  input logic reset_n,
  motor_pwm_rx_if.slave bus
);
  state_e st, nxt;
  logic tick, s1, s2, lvl, lvl_d, rise, fall, timeout, report;
  logic [CNT_W-1:0] hi_cnt, per_cnt, wid;
  cls_t cls;
  motor_pwm_tick_gen #(.DIVISOR(DIVISOR)) u_tick (.clk(clk), .reset_n(reset_n), .tick(tick));
  // Chain resets high: a pulse already in progress at reset release must not look like a rise
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {s1, s2} <= 2'b11;
    else {s1, s2} <= {bus.pwm_in, s1};
`ifdef MOTOR_PWM_RX_GLITCH_EN
  localparam int GW = $clog2(GLITCH_LEN + 1);
  logic [GW-1:0] gcnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      lvl  <= 1'b1;
      gcnt <= '0;
    end else if (s2 == lvl) gcnt <= '0;
    else if (gcnt == GW'(GLITCH_LEN - 1)) begin
      lvl  <= s2;
      gcnt <= '0;
    end else gcnt <= gcnt + 1'b1;
`else
  assign lvl = s2;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) lvl_d <= 1'b1;
    else lvl_d <= lvl;
  assign rise    = lvl & ~lvl_d;
  assign fall    = ~lvl & lvl_d;
  assign timeout = per_cnt == CNT_W'(TIMEOUT);
  assign cls     = classify(32'(wid), TOL);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt    = rise ? HIGH : timeout ? IDLE : (fall && st == HIGH) ? LOW : st;
    report = rise && st == LOW;
  end
  // A rise clears the counters outright, so a tick in the same clk is dropped
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hi_cnt          <= '0;
      per_cnt         <= '0;
      wid             <= '0;
      bus.width_out   <= '0;
      bus.period_out  <= '0;
      bus.meas_valid  <= 1'b0;
      bus.sw_code     <= 2'b00;
      bus.code_ok     <= 1'b0;
      bus.signal_lost <= 1'b1;
    end else begin
      bus.meas_valid <= report;
      hi_cnt  <= rise ? '0 : hi_cnt + CNT_W'(tick && !(&hi_cnt));
      per_cnt <= rise ? '0 : per_cnt + CNT_W'(tick && !(&per_cnt));
      if (fall && st == HIGH) wid <= hi_cnt;
      if (rise) bus.signal_lost <= 1'b0;
      else if (timeout) bus.signal_lost <= 1'b1;
      if (report) begin
        bus.width_out  <= wid;
        bus.period_out <= per_cnt;
        bus.code_ok    <= cls.ok;
        if (cls.ok) bus.sw_code <= cls.code;
      end
    end
endmodule

// File: tb/tb_motor_pwm_rx.sv
// tb_motor_pwm_rx: directed vector table plus timeout, reset and glitch sequences (DIVISOR=1, one tick per clk).
module tb_motor_pwm_rx;
`ifdef MOTOR_PWM_RX_GLITCH_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  localparam int TIMEOUT = 4000;
  typedef struct {
    int         hi;
    int         lo;
    bit         mv;
    int         ew;
    int         ep;
    logic [1:0] ec;
    bit         eok;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int n_mv = 0;
  vec_t tv[9];
  motor_pwm_rx_if #(.CNT_W(16)) bus ();
  motor_pwm_rx #(.DIVISOR(1), .CNT_W(16), .TIMEOUT(TIMEOUT), .TOL(5)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #2;
    if (bus.meas_valid) n_mv++;
  end
  task automatic check(input string nm, input int act, input int exp, input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (+/-%0d)", nm, act, exp, tol);
    end
  endtask
  // Drive one period starting at a negedge; the report of the previous period is checked LAT clks after the rise.
  task automatic pulse(input int hi, input int lo, input bit mv, input int ew, input int ep,
                       input logic [1:0] ec, input bit eok, input string nm);
    bus.pwm_in = 1'b1;
    repeat (LAT) @(negedge clk);
    check({nm, " mv"}, int'(bus.meas_valid), int'(mv), 0);
    if (mv) begin
      check({nm, " width"}, int'(bus.width_out), ew, 1);
      check({nm, " period"}, int'(bus.period_out), ep, 1);
      check({nm, " code"}, int'(bus.sw_code), int'(ec), 0);
      check({nm, " ok"}, int'(bus.code_ok), int'(eok), 0);
    end
    @(negedge clk);
    check({nm, " strobe end"}, int'(bus.meas_valid), 0, 0);
    repeat (hi - LAT - 1) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask
  initial begin
    int n, n0;
    tv[0] = '{130, 1870, 1'b0, 0, 0, 2'b00, 1'b0};
    tv[1] = '{130, 1870, 1'b1, 130, 2000, 2'b01, 1'b1};
    tv[2] = '{153, 1847, 1'b1, 130, 2000, 2'b01, 1'b1};
    tv[3] = '{170, 1830, 1'b1, 153, 2000, 2'b00, 1'b1};
    tv[4] = '{100, 1900, 1'b1, 170, 2000, 2'b10, 1'b1};
    tv[5] = '{140, 960, 1'b1, 100, 2000, 2'b10, 1'b0};
    tv[6] = '{150, 1850, 1'b1, 140, 1100, 2'b10, 1'b0};
    tv[7] = '{130, 1870, 1'b1, 150, 2000, 2'b00, 1'b1};
    tv[8] = '{130, 1870, 1'b1, 130, 2000, 2'b01, 1'b1};
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst width", int'(bus.width_out), 0, 0);
    check("rst period", int'(bus.period_out), 0, 0);
    check("rst mv", int'(bus.meas_valid), 0, 0);
    check("rst code", int'(bus.sw_code), 0, 0);
    check("rst ok", int'(bus.code_ok), 0, 0);
    check("rst lost", int'(bus.signal_lost), 1, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 9; i++)
      pulse(tv[i].hi, tv[i].lo, tv[i].mv, tv[i].ew, tv[i].ep, tv[i].ec, tv[i].eok, $sformatf("vec%0d", i));
    check("lost in run", int'(bus.signal_lost), 0, 0);
    pulse(130, 0, 1'b1, 130, 2000, 2'b01, 1'b1, "pre timeout");
    n = 130;
    while (!bus.signal_lost && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("timeout clks", n, LAT + TIMEOUT + 1, 2);
    check("timeout code held", int'(bus.sw_code), 1, 0);
    pulse(130, 1870, 1'b0, 0, 0, 2'b00, 1'b0, "lost rise");
    check("lost cleared", int'(bus.signal_lost), 0, 0);
    pulse(130, 1870, 1'b1, 130, 2000, 2'b01, 1'b1, "after lost");
    bus.pwm_in = 1'b1;
    repeat (50) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid rst width", int'(bus.width_out), 0, 0);
    check("mid rst period", int'(bus.period_out), 0, 0);
    check("mid rst code", int'(bus.sw_code), 0, 0);
    check("mid rst ok", int'(bus.code_ok), 0, 0);
    check("mid rst lost", int'(bus.signal_lost), 1, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (77) @(negedge clk);
    check("post rst lost", int'(bus.signal_lost), 1, 0);
    bus.pwm_in = 1'b0;
    repeat (1870) @(negedge clk);
    pulse(130, 1870, 1'b0, 0, 0, 2'b00, 1'b0, "post rst first");
    pulse(130, 1870, 1'b1, 130, 2000, 2'b01, 1'b1, "post rst second");
    pulse(130, 500, 1'b1, 130, 2000, 2'b01, 1'b1, "pre glitch");
    n0 = n_mv;
    bus.pwm_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.pwm_in = 1'b0;
`ifdef MOTOR_PWM_RX_GLITCH_EN
    repeat (1368) @(negedge clk);
    check("glitch ignored", n_mv, n0, 0);
    pulse(130, 1870, 1'b1, 130, 2000, 2'b01, 1'b1, "post glitch");
`else
    @(negedge clk);
    check("glitch mv", int'(bus.meas_valid), 1, 0);
    check("glitch period", int'(bus.period_out), 630, 1);
    check("glitch strobes", n_mv, n0 + 1, 0);
    repeat (1367) @(negedge clk);
    pulse(130, 1870, 1'b1, 2, 1370, 2'b01, 1'b0, "post glitch");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
